mem_store_scheduler: RTL and testbench
======================================

# mem_store_scheduler

Store-side scheduler for a loadless memory controller. It arbitrates N store ports round-robin onto the single BRAM write port and tracks outstanding stores with a signed counter. It runs a start/run/drain/end FSM that signals memory completion to the surrounding dataflow circuit. It sits between the circuit's store ports and the BRAM write interface, and owns all write sequencing and memory-end handshaking.

## Interface
- NUM_CONTROLS, 1, number of control (store-count) channels
- NUM_STORES, 2, number of store ports (≥1)
- DATA_TYPE, 32, store data width
- ADDR_TYPE, 32, store address width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low (state resets on rising edge while rst=0)
- memStart_valid / memStart_ready  in / out  1  start token
- memEnd_valid / memEnd_ready  out / in  1  completion token
- ctrlEnd_valid / ctrlEnd_ready  in / out  1  "no more control tokens"
- ctrl  in  NUM_CONTROLS*32  per-channel store count; channel i at [i*32+:32]
- ctrl_valid / ctrl_ready  in / out  NUM_CONTROLS  ctrl handshake; ctrl_ready tied all-1
- stAddr  in  NUM_STORES*ADDR_TYPE  store addresses
- stData  in  NUM_STORES*DATA_TYPE  store data
- stAddr_valid, stData_valid  in  NUM_STORES  per-port valids
- stAddr_ready, stData_ready  out  NUM_STORES  per-port readies; identical vectors
- storeEn  out  1  BRAM write enable (registered)
- storeAddr  out  ADDR_TYPE  BRAM write address (registered)
- storeData  out  DATA_TYPE  BRAM write data (registered)

## Operation
- FSM states IDLE, RUN, DRAIN, END; reset → IDLE.
- IDLE: memStart_ready=1. memStart_valid → RUN.
- RUN: ctrlEnd_ready=1. ctrlEnd_valid → DRAIN.
- DRAIN: when allDone → END.
- END: memEnd_valid=1. memEnd_ready → IDLE.
- Store acceptance is enabled only in RUN and DRAIN. Port i is eligible when stAddr_valid[i] and stData_valid[i] are both 1. An address without data, or data without address, is never granted.
- Arbitration is round-robin and grants at most one port per cycle.
  - Search starts at port (last_grant+1) mod NUM_STORES; last_grant resets to NUM_STORES-1, so port 0 has first priority.
  - last_grant updates only on a grant.
  - stAddr_ready[i] = stData_ready[i] = grant[i], combinational from the valids and the state.
- On grant of port i, the next edge loads storeEn=1, storeAddr=stAddr[i], storeData=stData[i]. With no grant, storeEn=0 and storeAddr/storeData hold their values.
- pending is a 32-bit signed counter, reset 0. Each cycle: pending ← pending + Σ ctrl[i] over ctrl_valid[i] − (grant ? 1 : 0).
  - All terms are summed in one cycle, so simultaneous ctrl and grant are exact.
  - Arithmetic wraps modulo 2^32.
  - pending may go transiently negative when a store precedes its count.
- allDone = (pending==0) && (ctrl_valid==0) && (storeEn==0). Because the registered write must have landed, END is never entered with a write in flight.
- ctrl tokens are accepted in every state, including IDLE and END.

## Timing
- Reset values: memStart_ready=1, memEnd_valid=0, ctrlEnd_ready=0, stAddr_ready/stData_ready=0, ctrl_ready=all-1, storeEn=0, storeAddr=0, storeData=0, pending=0.
- Grant to write latency: storeEn is high on the cycle after the grant, for exactly 1 cycle per store.
- Sustained throughput is 1 store per cycle when requests are continuous.
- memStart handshake cycle t: state=RUN at t+1, and the first grant is possible at t+1.
- DRAIN to END: END is entered on the edge after allDone is first observed. memEnd_valid holds until memEnd_ready.
- memStart_ready and memEnd_valid depend only on state. Readies never depend combinationally on memEnd_ready.
- rst=0 mid-operation aborts everything on that edge: any in-flight write is dropped (storeEn=0 next cycle), pending is cleared, and the state returns to IDLE.

## Test plan
- Reset: hold rst=0 for 2 cycles → all outputs at their reset values. memStart handshake → RUN next cycle, stAddr_ready=0 before it.
- Single store: ctrl[0]=1 valid 1 cycle, then port 0 stores addr 0x10 / data 0xAB. Expect storeEn=1, storeAddr=0x10, storeData=0xAB exactly 1 cycle after the grant, and pending=0.
- Round-robin: 3 ports all valid for 6 cycles → grant order 0,1,2,0,1,2. Then drop port 1 → order 0,2,0,2.
- Split valid: port 0 stAddr_valid=1, stData_valid=0 for 3 cycles → no grant, no storeEn. Raise stData_valid → granted that cycle.
- Drain ordering: ctrl=3, ctrlEnd handshake after the 1st store, remaining 2 stores 5 cycles apart.
  - Expect DRAIN until the 3rd write's storeEn cycle ends, then END. memEnd_valid stays high until memEnd_ready, then IDLE.
- Negative and simultaneous: store granted before ctrl → pending=−1. Next cycle ctrl=1 with a concurrent grant → pending=−1. Then ctrl=1 alone → pending=0.

Source files
------------

// File: rtl/mem_store_scheduler.sv
// mem_store_scheduler: round-robin store arbiter onto a single BRAM write
// port, with a signed outstanding-store counter and a start/run/drain/end
// FSM that signals memory completion.
module mem_store_scheduler #(
  parameter int NUM_CONTROLS = 1,
  parameter int NUM_STORES   = 2,
  parameter int DATA_TYPE    = 32,
  parameter int ADDR_TYPE    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             memStart_valid,
  output logic                             memStart_ready,
  output logic                             memEnd_valid,
  input  logic                             memEnd_ready,
  input  logic                             ctrlEnd_valid,
  output logic                             ctrlEnd_ready,
  input  logic [NUM_CONTROLS*32-1:0]       ctrl,
  input  logic [NUM_CONTROLS-1:0]          ctrl_valid,
  output logic [NUM_CONTROLS-1:0]          ctrl_ready,
  input  logic [NUM_STORES*ADDR_TYPE-1:0]  stAddr,
  input  logic [NUM_STORES*DATA_TYPE-1:0]  stData,
  input  logic [NUM_STORES-1:0]            stAddr_valid,
  input  logic [NUM_STORES-1:0]            stData_valid,
  output logic [NUM_STORES-1:0]            stAddr_ready,
  output logic [NUM_STORES-1:0]            stData_ready,
  output logic                             storeEn,
  output logic [ADDR_TYPE-1:0]             storeAddr,
  output logic [DATA_TYPE-1:0]             storeData
);

  localparam int unsigned NS    = NUM_STORES;
  localparam int unsigned IDX_W = (NUM_STORES > 1) ? $clog2(NUM_STORES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    END   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  memStart_ready_q, memStart_ready_d;
  logic                  memEnd_valid_q, memEnd_valid_d;
  logic                  ctrlEnd_ready_q, ctrlEnd_ready_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic                  storeEn_q, storeEn_d;
  logic [ADDR_TYPE-1:0]  storeAddr_q, storeAddr_d;
  logic [DATA_TYPE-1:0]  storeData_q, storeData_d;
  logic signed [31:0]    pending_q, pending_d;

  logic [NUM_STORES-1:0] eligible;
  logic [NUM_STORES-1:0] grant;
  logic                  grant_any;
  logic [IDX_W-1:0]      grant_idx;
  logic                  accept;
  logic                  all_done;
  logic [31:0]           ctrl_sum;
  int unsigned           cand;

  assign ctrl_ready     = '1;
  assign memStart_ready = memStart_ready_q;
  assign memEnd_valid   = memEnd_valid_q;
  assign ctrlEnd_ready  = ctrlEnd_ready_q;
  assign stAddr_ready   = grant;
  assign stData_ready   = grant;
  assign storeEn        = storeEn_q;
  assign storeAddr      = storeAddr_q;
  assign storeData      = storeData_q;

  assign eligible = stAddr_valid & stData_valid;
  assign accept   = (state_q == RUN) || (state_q == DRAIN);
  assign all_done = (pending_q == 32'sd0) && (ctrl_valid == '0) && !storeEn_q;

  // Round-robin search starting one past the last granted port.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (accept) begin
      for (int unsigned k = 0; k < NS; k++) begin
        cand = (32'(last_q) + 1 + k) % NS;
        if (!grant_any && eligible[cand]) begin
          grant[cand] = 1'b1;
          grant_any   = 1'b1;
          grant_idx   = IDX_W'(cand);
        end
      end
    end
  end

  // Next values for the write port, arbitration pointer and pending count.
  always_comb begin
    ctrl_sum = '0;
    for (int unsigned k = 0; k < NUM_CONTROLS; k++) begin
      if (ctrl_valid[k]) ctrl_sum = ctrl_sum + ctrl[k*32 +: 32];
    end
    pending_d   = pending_q + $signed(ctrl_sum) - (grant_any ? 32'sd1 : 32'sd0);
    last_d      = grant_any ? grant_idx : last_q;
    storeEn_d   = grant_any;
    storeAddr_d = grant_any ? stAddr[grant_idx*ADDR_TYPE +: ADDR_TYPE] : storeAddr_q;
    storeData_d = grant_any ? stData[grant_idx*DATA_TYPE +: DATA_TYPE] : storeData_q;
  end

  // FSM next state; handshake outputs are decoded from the next state so
  // they are registered alongside it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (memStart_valid) state_d = RUN;
      RUN:     if (ctrlEnd_valid)  state_d = DRAIN;
      DRAIN:   if (all_done)       state_d = END;
      END:     if (memEnd_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    memStart_ready_d = (state_d == IDLE);
    ctrlEnd_ready_d  = (state_d == RUN);
    memEnd_valid_d   = (state_d == END);
  end

  // All state, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      memStart_ready_q <= 1'b1;
      memEnd_valid_q   <= 1'b0;
      ctrlEnd_ready_q  <= 1'b0;
      last_q           <= IDX_W'(NUM_STORES - 1);
      storeEn_q        <= 1'b0;
      storeAddr_q      <= '0;
      storeData_q      <= '0;
      pending_q        <= '0;
    end else begin
      state_q          <= state_d;
      memStart_ready_q <= memStart_ready_d;
      memEnd_valid_q   <= memEnd_valid_d;
      ctrlEnd_ready_q  <= ctrlEnd_ready_d;
      last_q           <= last_d;
      storeEn_q        <= storeEn_d;
      storeAddr_q      <= storeAddr_d;
      storeData_q      <= storeData_d;
      pending_q        <= pending_d;
    end
  end

endmodule

// File: tb/tb_mem_store_scheduler.sv
// tb_mem_store_scheduler: table-driven vectors with a write scoreboard for a
// 3-port, 1-control-channel mem_store_scheduler.
module tb_mem_store_scheduler;

  localparam int NS = 3;

  logic          clk;
  logic          rst;
  logic          memStart_valid, memStart_ready;
  logic          memEnd_valid, memEnd_ready;
  logic          ctrlEnd_valid, ctrlEnd_ready;
  logic [31:0]   ctrl;
  logic [0:0]    ctrl_valid, ctrl_ready;
  logic [NS*32-1:0] stAddr, stData;
  logic [NS-1:0] stAddr_valid, stData_valid, stAddr_ready, stData_ready;
  logic          storeEn;
  logic [31:0]   storeAddr, storeData;

  mem_store_scheduler #(
    .NUM_CONTROLS(1),
    .NUM_STORES(NS),
    .DATA_TYPE(32),
    .ADDR_TYPE(32)
  ) dut (
    .clk(clk), .rst(rst),
    .memStart_valid(memStart_valid), .memStart_ready(memStart_ready),
    .memEnd_valid(memEnd_valid), .memEnd_ready(memEnd_ready),
    .ctrlEnd_valid(ctrlEnd_valid), .ctrlEnd_ready(ctrlEnd_ready),
    .ctrl(ctrl), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .stAddr(stAddr), .stData(stData),
    .stAddr_valid(stAddr_valid), .stData_valid(stData_valid),
    .stAddr_ready(stAddr_ready), .stData_ready(stData_ready),
    .storeEn(storeEn), .storeAddr(storeAddr), .storeData(storeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sc: pre-edge state 0=IDLE 1=RUN 2=DRAIN 3=END
  typedef struct {
    logic        rst, ms_v, me_r, ce_v, cv;
    logic [31:0] ctrl;
    logic [2:0]  av, dv, g;
    int          sc;
    logic [31:0] a0, d0;
  } vec_t;

  typedef struct {
    logic        en;
    logic [31:0] a, d;
  } wr_t;

  vec_t        tbl[$];
  wr_t         sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_pend = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic ms_v, input logic me_r, input logic ce_v,
                     input logic cv, input logic [31:0] c, input logic [2:0] av,
                     input logic [2:0] dv, input logic [2:0] g, input int sc);
    vec_t v;
    v.rst = r; v.ms_v = ms_v; v.me_r = me_r; v.ce_v = ce_v; v.cv = cv; v.ctrl = c;
    v.av = av; v.dv = dv; v.g = g; v.sc = sc;
    v.a0 = 32'h100 + 32'(tbl.size()) * 4;
    v.d0 = 32'hC0DE_0000 + 32'(tbl.size());
    tbl.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    wr_t e, got;
    int  idx;
    string tag;
    tag = $sformatf("v%0d", n);
    rst = v.rst; memStart_valid = v.ms_v; memEnd_ready = v.me_r;
    ctrlEnd_valid = v.ce_v; ctrl_valid = v.cv; ctrl = v.ctrl;
    stAddr_valid = v.av; stData_valid = v.dv;
    for (int p = 0; p < NS; p++) begin
      stAddr[p*32 +: 32] = v.a0 + 32'h1000 * 32'(p);
      stData[p*32 +: 32] = v.d0 + 32'h0100_0000 * 32'(p);
    end
    #1;
    check({tag, " stAddr_ready"}, 32'(stAddr_ready), 32'(v.g));
    check({tag, " stData_ready"}, 32'(stData_ready), 32'(v.g));
    check({tag, " memStart_ready"}, 32'(memStart_ready), 32'(v.sc == 0));
    check({tag, " ctrlEnd_ready"}, 32'(ctrlEnd_ready), 32'(v.sc == 1));
    check({tag, " memEnd_valid"}, 32'(memEnd_valid), 32'(v.sc == 3));
    check({tag, " ctrl_ready"}, 32'(ctrl_ready), 32'd1);
    // expected result of this cycle's edge
    idx = v.g[1] ? 1 : (v.g[2] ? 2 : 0);
    if (!v.rst) begin
      m_addr = '0; m_data = '0; m_pend = 0;
      e.en = 1'b0;
    end else begin
      if (v.cv) m_pend = m_pend + int'(v.ctrl);
      if (v.g != 3'b000) begin
        m_addr = v.a0 + 32'h1000 * 32'(idx);
        m_data = v.d0 + 32'h0100_0000 * 32'(idx);
        m_pend = m_pend - 1;
        e.en = 1'b1;
      end else begin
        e.en = 1'b0;
      end
    end
    e.a = m_addr; e.d = m_data;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got.en = storeEn; got.a = storeAddr; got.d = storeData;
    e = sbq.pop_front();
    check({tag, " storeEn"}, 32'(got.en), 32'(e.en));
    check({tag, " storeAddr"}, got.a, e.a);
    check({tag, " storeData"}, got.d, e.d);
    check({tag, " pending"}, dut.pending_q, 32'(m_pend));
  endtask

  initial begin
    rst = 1'b0; memStart_valid = 1'b0; memEnd_ready = 1'b0; ctrlEnd_valid = 1'b0;
    ctrl = '0; ctrl_valid = '0; stAddr = '0; stData = '0;
    stAddr_valid = '0; stData_valid = '0;

    // idle / start
    add(1,0,0,0,0,0, 3'b001,3'b001,3'b000, 0);
    add(1,1,0,0,0,0, 3'b000,3'b000,3'b000, 0);
    // single store
    add(1,0,0,0,1,1, 3'b000,3'b000,3'b000, 1);
    add(1,0,0,0,0,0, 3'b001,3'b001,3'b001, 1);
    tbl[tbl.size()-1].a0 = 32'h10;
    tbl[tbl.size()-1].d0 = 32'hAB;
    add(1,0,0,0,0,0, 3'b000,3'b000,3'b000, 1);
    // round-robin, all three ports continuous (pointer left at port 0)
    add(1,0,0,0,1,6, 3'b111,3'b111,3'b010, 1);
    add(1,0,0,0,0,0, 3'b111,3'b111,3'b100, 1);
    add(1,0,0,0,0,0, 3'b111,3'b111,3'b001, 1);
    add(1,0,0,0,0,0, 3'b111,3'b111,3'b010, 1);
    add(1,0,0,0,0,0, 3'b111,3'b111,3'b100, 1);
    add(1,0,0,0,0,0, 3'b111,3'b111,3'b001, 1);
    // port 1 dropped
    add(1,0,0,0,1,4, 3'b101,3'b101,3'b100, 1);
    add(1,0,0,0,0,0, 3'b101,3'b101,3'b001, 1);
    add(1,0,0,0,0,0, 3'b101,3'b101,3'b100, 1);
    add(1,0,0,0,0,0, 3'b101,3'b101,3'b001, 1);
    // split valid
    add(1,0,0,0,1,1, 3'b001,3'b000,3'b000, 1);
    add(1,0,0,0,0,0, 3'b001,3'b000,3'b000, 1);
    add(1,0,0,0,0,0, 3'b001,3'b000,3'b000, 1);
    add(1,0,0,0,0,0, 3'b001,3'b001,3'b001, 1);
    // negative and simultaneous
    add(1,0,0,0,0,0, 3'b010,3'b010,3'b010, 1);
    add(1,0,0,0,1,1, 3'b001,3'b001,3'b001, 1);
    add(1,0,0,0,1,1, 3'b000,3'b000,3'b000, 1);
    // drain ordering
    add(1,0,0,0,1,3, 3'b010,3'b010,3'b010, 1);
    add(1,0,0,1,0,0, 3'b000,3'b000,3'b000, 1);
    for (int i = 0; i < 4; i++) add(1,0,0,0,0,0, 3'b000,3'b000,3'b000, 2);
    add(1,0,0,0,0,0, 3'b100,3'b100,3'b100, 2);
    for (int i = 0; i < 4; i++) add(1,0,0,0,0,0, 3'b000,3'b000,3'b000, 2);
    add(1,0,0,0,0,0, 3'b001,3'b001,3'b001, 2);
    add(1,0,0,0,0,0, 3'b000,3'b000,3'b000, 2);
    add(1,0,0,0,0,0, 3'b000,3'b000,3'b000, 2);
    add(1,0,0,0,0,0, 3'b000,3'b000,3'b000, 3);
    add(1,0,0,0,0,0, 3'b000,3'b000,3'b000, 3);
    add(1,0,1,0,0,0, 3'b000,3'b000,3'b000, 3);
    // ctrl accepted in IDLE, then restart and abort mid-write
    add(1,0,0,0,1,2, 3'b000,3'b000,3'b000, 0);
    add(1,1,0,0,0,0, 3'b000,3'b000,3'b000, 0);
    add(1,0,0,0,0,0, 3'b010,3'b010,3'b010, 1);
    add(0,0,0,0,0,0, 3'b100,3'b100,3'b100, 1);
    add(1,0,0,0,0,0, 3'b000,3'b000,3'b000, 0);

    // reset held for two cycles
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset memStart_ready", 32'(memStart_ready), 32'd1);
    check("reset memEnd_valid", 32'(memEnd_valid), 32'd0);
    check("reset ctrlEnd_ready", 32'(ctrlEnd_ready), 32'd0);
    check("reset stAddr_ready", 32'(stAddr_ready), 32'd0);
    check("reset stData_ready", 32'(stData_ready), 32'd0);
    check("reset ctrl_ready", 32'(ctrl_ready), 32'd1);
    check("reset storeEn", 32'(storeEn), 32'd0);
    check("reset storeAddr", storeAddr, 32'd0);
    check("reset storeData", storeData, 32'd0);
    check("reset pending", dut.pending_q, 32'd0);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
